dibit_serializer: RTL and testbench

//   Transmit side of the 2-bit datapath. Accepts DATA_W-bit words on a valid/ready

---
 rtl/dibit_serializer_pkg.sv | 12 +
 rtl/dibit_serializer.sv | 112 +++++++++++
 tb/tb_dibit_serializer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dibit_serializer_pkg.sv
// Shared types and constants for the 2-bit transmit datapath.
package dibit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DIBIT_W = 2;

endpackage

// File: rtl/dibit_serializer.sv
// Word-to-dibit serializer: accepts DATA_W-bit words on valid/ready and emits
// registered 2-bit dibits MSB first with first/last framing strobes.
module dibit_serializer
  import dibit_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DIBIT_W-1:0] out,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eof
);

  localparam int NDIB = DATA_W / 2;
  localparam int CW   = (NDIB > 1) ? $clog2(NDIB) : 1;
  localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CW-1:0] DIB_LAST   = CW'(NDIB - 1);
  localparam logic [CW-1:0] DIB_PENULT = CW'(NDIB - 2);
  localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  if (DATA_W < 4 || (DATA_W % 2) != 0) begin : g_bad_width
    $error("dibit_serializer: DATA_W must be even and >= 4");
  end

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     dib_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              accept;
  logic              last_dib;

  assign last_dib = (dib_cnt == DIB_LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: in_ready = last_dib && (GAP_CYCLES == 0);
      GAP:   in_ready = (gap_cnt == GAP_LAST);
      default: in_ready = 1'b0;
    endcase
    if (sys_rst) in_ready = 1'b0;
    accept = in_valid && in_ready;

    unique case (state)
      IDLE: if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_dib) begin
          if (accept)              state_nxt = SHIFT;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = accept ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      shreg     <= '0;
      dib_cnt   <= '0;
      gap_cnt   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg     <= in_data;
        out       <= in_data[DATA_W-1 -: DIBIT_W];
        out_valid <= 1'b1;
        out_sof   <= 1'b1;
        out_eof   <= 1'b0;
        dib_cnt   <= '0;
      end else begin
        unique case (state)
          SHIFT: begin
            if (!last_dib) begin
              // shreg keeps the dibit on out at its top, so the next one sits just below
              shreg   <= {shreg[DATA_W-DIBIT_W-1:0], {DIBIT_W{1'b0}}};
              out     <= shreg[DATA_W-DIBIT_W-1 -: DIBIT_W];
              dib_cnt <= dib_cnt + 1'b1;
              out_sof <= 1'b0;
              out_eof <= (dib_cnt == DIB_PENULT);
            end else begin
              out_valid <= 1'b0;
              out_sof   <= 1'b0;
              out_eof   <= 1'b0;
              gap_cnt   <= '0;
            end
          end
          GAP:     gap_cnt <= gap_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dibit_serializer.sv
// Directed bench for dibit_serializer: three instances cover back-to-back,
// forced-gap and 16-bit word configurations.
module tb_dibit_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_data, b_data;
  logic [15:0] c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_ready, b_ready, c_ready;
  logic [1:0]  a_out, b_out, c_out;
  logic        a_ov, b_ov, c_ov;
  logic        a_sof, b_sof, c_sof;
  logic        a_eof, b_eof, c_eof;

  dibit_serializer #(.DATA_W(8), .GAP_CYCLES(0)) u_a (
    .sys_clk(clk), .sys_rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out(a_out), .out_valid(a_ov), .out_sof(a_sof), .out_eof(a_eof));

  dibit_serializer #(.DATA_W(8), .GAP_CYCLES(2)) u_b (
    .sys_clk(clk), .sys_rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out(b_out), .out_valid(b_ov), .out_sof(b_sof), .out_eof(b_eof));

  dibit_serializer #(.DATA_W(16), .GAP_CYCLES(0)) u_c (
    .sys_clk(clk), .sys_rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out(c_out), .out_valid(c_ov), .out_sof(c_sof), .out_eof(c_eof));

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  t3_dib [8] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
  logic [1:0]  t6_dib [8] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [15:0] c_words [4] = '{16'hC35A, 16'h1234, 16'hABCD, 16'h0F0F};

  // Reassembles words leaving instance C from its framed dibit stream
  logic [15:0] cur = '0;
  logic [15:0] rx [$];
  int ov_cnt = 0, sof_cnt = 0, eof_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (c_ov) begin
      ov_cnt++;
      if (c_sof) sof_cnt++;
      if (c_eof) eof_cnt++;
      if (c_sof && c_eof) both_cnt++;
      cur = c_sof ? {14'd0, c_out} : {cur[13:0], c_out};
      if (c_eof) rx.push_back(cur);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input int inst, input string tag, input logic [1:0] d,
                    input logic v, input logic s, input logic e, input logic r);
    logic [1:0] od;
    logic ov, os, oe, orr;
    case (inst)
      0:       begin od = a_out; ov = a_ov; os = a_sof; oe = a_eof; orr = a_ready; end
      1:       begin od = b_out; ov = b_ov; os = b_sof; oe = b_eof; orr = b_ready; end
      default: begin od = c_out; ov = c_ov; os = c_sof; oe = c_eof; orr = c_ready; end
    endcase
    chk({tag, ".out"},   32'(od),  32'(d));
    chk({tag, ".valid"}, 32'(ov),  32'(v));
    chk({tag, ".sof"},   32'(os),  32'(s));
    chk({tag, ".eof"},   32'(oe),  32'(e));
    chk({tag, ".ready"}, 32'(orr), 32'(r));
  endtask

  task automatic send_c(input logic [15:0] w);
    int unsigned gap;
    logic acc;
    gap = $urandom_range(0, 3);
    for (int unsigned k = 0; k < gap; k++) @(negedge clk);
    c_data  = w;
    c_valid = 1'b1;
    acc     = 1'b0;
    for (int unsigned k = 0; k < 20 && !acc; k++) begin
      if (c_ready) acc = 1'b1;
      @(negedge clk);
    end
    c_valid = 1'b0;
    chk("t6_accept", 32'(acc), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; b_data = '0; c_data = '0;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b0;

    // 1. reset held with in_valid asserted
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      ex(0, "t1_rstA", 2'd0, 0, 0, 0, 0);
      ex(1, "t1_rstB", 2'd0, 0, 0, 0, 0);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1 ex(0, "t1_rel", 2'd0, 0, 0, 0, 1);

    // 2. single word B4
    @(negedge clk);
    a_data = 8'hB4; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
    ex(0, "t2_d0", 2'd2, 1, 1, 0, 0);
    @(negedge clk); ex(0, "t2_d1", 2'd3, 1, 0, 0, 0);
    @(negedge clk); ex(0, "t2_d2", 2'd1, 1, 0, 0, 0);
    @(negedge clk); ex(0, "t2_d3", 2'd0, 1, 0, 1, 1);
    @(negedge clk); ex(0, "t2_idle", 2'd0, 0, 0, 0, 1);

    // 3. back-to-back B4, 1E
    a_data = 8'hB4; a_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) a_data = 8'h1E;
      if (i == 4) a_valid = 1'b0;
      ex(0, $sformatf("t3_d%0d", i), t3_dib[i], 1, (i == 0 || i == 4),
         (i == 3 || i == 7), (i == 3 || i == 7));
    end
    @(negedge clk); ex(0, "t3_idle", 2'd2, 0, 0, 0, 1);

    // 4. GAP_CYCLES=2 instance, B4 then 1E with valid held
    b_data = 8'hB4; b_valid = 1'b1;
    chk("t4_ready0", 32'(b_ready), 32'd1);
    @(negedge clk); ex(1, "t4_k1", 2'd2, 1, 1, 0, 0);
    @(negedge clk); ex(1, "t4_k2", 2'd3, 1, 0, 0, 0);
    @(negedge clk); ex(1, "t4_k3", 2'd1, 1, 0, 0, 0);
    @(negedge clk); ex(1, "t4_k4", 2'd0, 1, 0, 1, 0); b_data = 8'h1E;
    @(negedge clk); ex(1, "t4_gap0", 2'd0, 0, 0, 0, 0);
    @(negedge clk); ex(1, "t4_gap1", 2'd0, 0, 0, 0, 1);
    @(negedge clk); ex(1, "t4_k7", 2'd0, 1, 1, 0, 0); b_valid = 1'b0;
    @(negedge clk); ex(1, "t4_k8", 2'd1, 1, 0, 0, 0);
    @(negedge clk); ex(1, "t4_k9", 2'd3, 1, 0, 0, 0);
    @(negedge clk); ex(1, "t4_k10", 2'd2, 1, 0, 1, 0);
    @(negedge clk); ex(1, "t4_k11", 2'd2, 0, 0, 0, 0);
    @(negedge clk); ex(1, "t4_k12", 2'd2, 0, 0, 0, 1);
    @(negedge clk); ex(1, "t4_k13", 2'd2, 0, 0, 0, 1);

    // 5. reset in the middle of FF, then a clean 00 frame
    a_data = 8'hFF; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
    ex(0, "t5_d0", 2'd3, 1, 1, 0, 0);
    @(negedge clk); ex(0, "t5_d1", 2'd3, 1, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk); ex(0, "t5_rst", 2'd0, 0, 0, 0, 0);
    rst = 1'b0; a_data = 8'h00; a_valid = 1'b1;
    #1 chk("t5_ready", 32'(a_ready), 32'd1);
    @(negedge clk); a_valid = 1'b0;
    ex(0, "t5_n0", 2'd0, 1, 1, 0, 0);
    @(negedge clk); ex(0, "t5_n1", 2'd0, 1, 0, 0, 0);
    @(negedge clk); ex(0, "t5_n2", 2'd0, 1, 0, 0, 0);
    @(negedge clk); ex(0, "t5_n3", 2'd0, 1, 0, 1, 1);
    @(negedge clk); ex(0, "t5_idle", 2'd0, 0, 0, 0, 1);

    // 6. 16-bit words: directed C35A, then random input gaps
    c_data = 16'hC35A; c_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) c_valid = 1'b0;
      ex(2, $sformatf("t6_d%0d", i), t6_dib[i], 1, (i == 0), (i == 7), (i == 7));
    end
    @(negedge clk); ex(2, "t6_idle", 2'd2, 0, 0, 0, 1);
    for (int unsigned i = 1; i < 4; i++) send_c(c_words[i]);
    for (int unsigned i = 0; i < 12; i++) @(negedge clk);

    chk("t6_nwords", 32'(rx.size()), 32'd4);
    for (int unsigned i = 0; i < 4; i++)
      chk($sformatf("t6_word%0d", i), (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD_0000,
          32'(c_words[i]));
    chk("t6_ov_cnt", 32'(ov_cnt), 32'd32);
    chk("t6_sof_cnt", 32'(sof_cnt), 32'd4);
    chk("t6_eof_cnt", 32'(eof_cnt), 32'd4);
    chk("t6_sof_eof", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
